// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: run/step/halt PC-enable sequencer with halt drain; optional cycle counter under PIPELINE_RUN_CONTROLLER_CYCLE_COUNT_EN
module pipeline_run_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int STEP_WIDTH = 16,
   parameter int CNT_WIDTH = 32,
   parameter int DRAIN_CYCLES = 4,
   parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input logic clk,
   input logic reset,
   input logic cmd_valid,
   output logic cmd_ready,
   input logic [1:0] cmd_op,
   input logic [STEP_WIDTH-1:0] cmd_arg,
   input logic [DATA_WIDTH-1:0] pc_instr_in,
   output logic pc_enable_out,
   output logic busy,
   output logic done,
   output logic halted,
   output logic [CNT_WIDTH-1:0] cycle_count
);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, DRAIN = 3'd3, DONE = 3'd4;
   localparam logic [1:0] OP_RUN = 2'b01, OP_STEP = 2'b10, OP_ABORT = 2'b11;
   logic [2:0] state;
   logic [STEP_WIDTH-1:0] step_cnt;
   logic [DW-1:0] drain_cnt;
   logic halt_hit, accept, running;
   assign halt_hit = pc_instr_in == HALT_INSTR;
   assign running = state == RUN || state == STEP;
   assign pc_enable_out = running & ~halt_hit;
   assign cmd_ready = state == IDLE || running;
   assign accept = cmd_valid & cmd_ready;
   assign busy = running || state == DRAIN;
   assign halted = state == DONE;
   // sequencer: abort beats halt, halt beats step completion; drain then sticky DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         step_cnt <= '0;
         drain_cnt <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && cmd_op == OP_RUN) state <= RUN;
               else if (accept && cmd_op == OP_STEP) begin
                  state <= STEP;
                  step_cnt <= cmd_arg == '0 ? STEP_WIDTH'(1) : cmd_arg;
               end
            end
            RUN, STEP: begin
               if (accept && cmd_op == OP_ABORT) state <= IDLE;
               else if (halt_hit) begin
                  state <= DRAIN;
                  drain_cnt <= DW'(DRAIN_CYCLES);
               end else if (state == STEP) begin
                  step_cnt <= step_cnt - 1'b1;
                  if (step_cnt == STEP_WIDTH'(1)) begin
                     state <= IDLE;
                     done <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt - 1'b1;
               if (drain_cnt == DW'(1)) begin
                  state <= DONE;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
`ifdef PIPELINE_RUN_CONTROLLER_CYCLE_COUNT_EN
   // saturating count of PC-enabled cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cycle_count <= '0;
      else if (pc_enable_out && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
   end
`else
   assign cycle_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller: directed plan plus random commands against a behavioural model
module tb_pipeline_run_controller;
   localparam int SW = 16, CW = 4, DC = 4;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   logic clk = 0, reset = 1, cmd_valid = 0;
   logic [1:0] cmd_op = 0;
   logic [SW-1:0] cmd_arg = 0;
   logic [31:0] pc_instr_in = 0;
   logic cmd_ready, pc_enable_out, busy, done, halted;
   logic [CW-1:0] cycle_count;
   int checks = 0, errors = 0, n_en = 0, n_done = 0, n_busy = 0;
   int m_mode = 0, m_left = 0, m_drain = 0, m_cnt = 0;
   logic m_done = 0;
   bit m_hit, m_en, m_acc;

   pipeline_run_controller #(.DATA_WIDTH(32), .STEP_WIDTH(SW), .CNT_WIDTH(CW), .DRAIN_CYCLES(DC), .HALT_INSTR(HALT)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_arg(cmd_arg), .pc_instr_in(pc_instr_in), .pc_enable_out(pc_enable_out), .busy(busy),
      .done(done), .halted(halted), .cycle_count(cycle_count));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] nh();
      return $urandom() & 32'h7FFF_FFFF;
   endfunction

   function automatic logic [31:0] exp_cnt(input int c);
`ifdef PIPELINE_RUN_CONTROLLER_CYCLE_COUNT_EN
      return c;
`else
      return 0;
`endif
   endfunction

   // model modes: 0 idle, 1 run, 2 step, 3 drain, 4 done
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode = 0; m_left = 0; m_drain = 0; m_cnt = 0; m_done = 0;
      end else begin
         m_hit = pc_instr_in == HALT;
         m_en = (m_mode == 1 || m_mode == 2) && !m_hit;
         m_acc = cmd_valid && m_mode <= 2;
         m_done = 0;
         if (m_en && m_cnt < (1 << CW) - 1) m_cnt++;
         if (m_mode == 0) begin
            if (m_acc && cmd_op == 1) m_mode = 1;
            else if (m_acc && cmd_op == 2) begin
               m_mode = 2;
               m_left = cmd_arg == 0 ? 1 : int'(cmd_arg);
            end
         end else if (m_mode <= 2) begin
            if (m_acc && cmd_op == 3) m_mode = 0;
            else if (m_hit) begin
               m_mode = 3;
               m_drain = DC;
            end else if (m_mode == 2) begin
               m_left--;
               if (m_left == 0) begin
                  m_mode = 0;
                  m_done = 1;
               end
            end
         end else if (m_mode == 3) begin
            m_drain--;
            if (m_drain == 0) begin
               m_mode = 4;
               m_done = 1;
            end
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      #1;
      chk("pc_enable_out", pc_enable_out, (m_mode == 1 || m_mode == 2) && pc_instr_in != HALT);
      chk("cmd_ready", cmd_ready, m_mode <= 2);
      chk("busy", busy, m_mode >= 1 && m_mode <= 3);
      chk("done", done, m_done);
      chk("halted", halted, m_mode == 4);
      chk("cycle_count", cycle_count, exp_cnt(m_cnt));
   end

   task automatic tick(input logic v, input logic [1:0] op, input int arg, input logic [31:0] ins);
      @(negedge clk);
      cmd_valid = v; cmd_op = op; cmd_arg = SW'(arg); pc_instr_in = ins;
      #1;
      n_en += int'(pc_enable_out);
      n_done += int'(done);
      n_busy += int'(busy);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(0, 0, 0, nh());
   endtask

   task automatic do_reset();
      reset = 1;
      idle(2);
      reset = 0;
   endtask

   initial begin
      do_reset();
      idle(5);
      chk("rst_en", pc_enable_out, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", cycle_count, 0);
      n_en = 0; n_done = 0;
      tick(1, 2, 3, nh());
      idle(6);
      chk("step3_en", n_en, 3);
      chk("step3_done", n_done, 1);
      chk("step3_idle", busy, 0);
      chk("step3_cnt", cycle_count, exp_cnt(3));
      n_en = 0; n_done = 0;
      tick(1, 2, 0, nh());
      idle(4);
      chk("step0_en", n_en, 1);
      chk("step0_done", n_done, 1);
      do_reset();
      tick(1, 1, 0, nh());
      repeat (9) begin
         tick(0, 0, 0, nh());
         chk("run_en", pc_enable_out, 1);
      end
      tick(0, 0, 0, HALT);
      chk("halt_en", pc_enable_out, 0);
      chk("halt_busy", busy, 1);
      n_busy = 0; n_done = 0;
      idle(4);
      chk("drain_busy", n_busy, 4);
      chk("drain_nodone", n_done, 0);
      idle(1);
      chk("halt_done", done, 1);
      chk("halt_halted", halted, 1);
      chk("halt_ready", cmd_ready, 0);
      chk("halt_cnt", cycle_count, exp_cnt(9));
      idle(3);
      chk("done_sticky", halted, 1);
      do_reset();
      tick(1, 1, 0, nh());
      idle(2);
      n_done = 0;
      tick(1, 3, 0, HALT);
      chk("abort_halt_en", pc_enable_out, 0);
      idle(1);
      chk("abort_busy", busy, 0);
      idle(5);
      chk("abort_nodone", n_done, 0);
      tick(1, 1, 0, nh());
      chk("abort_rerun_ready", cmd_ready, 1);
      tick(0, 0, 0, nh());
      chk("abort_rerun_en", pc_enable_out, 1);
      tick(1, 3, 0, nh());
      do_reset();
      tick(1, 1, 0, nh());
      idle(3);
      tick(0, 0, 0, HALT);
      idle(1);
      n_done = 0;
      @(negedge clk);
      reset = 1;
      #1;
      chk("rstdrain_busy", busy, 0);
      chk("rstdrain_halted", halted, 0);
      chk("rstdrain_ready", cmd_ready, 1);
      idle(1);
      reset = 0;
      idle(6);
      chk("rstdrain_nodone", n_done, 0);
      chk("rstdrain_idle", halted, 0);
      for (int i = 0; i < 4000; i++) begin
         reset = (halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0;
         tick($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 5),
              $urandom_range(0, 24) == 0 ? HALT : nh());
      end
      reset = 0;
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipeline_run_controller.md
# pipeline_run_controller

Run/step/halt sequencer for the five-stage pipeline. It sits between the debug command source and the pipeline's `pc_enable_in`, and decides on which cycles the PC may advance. It detects the halt instruction at fetch, freezes the PC on it and drains the in-flight instructions before reporting completion. An optional counter reports how many cycles the PC was enabled.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: fetched instruction width.
- `STEP_WIDTH`, default 16: width of the step-count argument.
- `CNT_WIDTH`, default 32: width of the enabled-cycle counter.
- `DRAIN_CYCLES`, default 4: cycles the PC is held after halt detection (ID, EX, MEM, WB), at least 1.
- `HALT_INSTR`, default 32'hFFFF_FFFF: instruction encoding that ends a program.

**Ports**
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: controller accepts the command this cycle.
- `cmd_op`, in, 2: 00 NOP, 01 RUN, 10 STEP, 11 ABORT.
- `cmd_arg`, in, STEP_WIDTH: step count for STEP; 0 is treated as 1.
- `pc_instr_in`, in, DATA_WIDTH: instruction currently output by fetch.
- `pc_enable_out`, out, 1: drives the pipeline's `pc_enable_in`.
- `busy`, out, 1: high in RUN, STEP and DRAIN.
- `done`, out, 1: one-cycle completion pulse.
- `halted`, out, 1: high in DONE.
- `cycle_count`, out, CNT_WIDTH: number of cycles with the PC enabled.

## Operation

- **States:** IDLE, RUN, STEP, DRAIN, DONE. The state, the step counter, the drain counter, `done` and `cycle_count` are all registers.
- **Handshake:** a command transfers on `cmd_valid & cmd_ready`.
  - `cmd_ready` is 1 in IDLE, RUN and STEP, and 0 in DRAIN and DONE.
- **IDLE:**
  - RUN goes to RUN.
  - STEP loads the step counter with `max(cmd_arg, 1)` and goes to STEP.
  - NOP and ABORT are accepted with no effect.
- **RUN / STEP, common rules:**
  - `halt_hit = (pc_instr_in == HALT_INSTR)`.
  - `pc_enable_out = (state is RUN or STEP) & ~halt_hit`; this is combinational from the state and `pc_instr_in`.
  - The PC never advances past the halt instruction.
- **RUN:**
  - `halt_hit` goes to DRAIN.
  - An accepted ABORT goes to IDLE.
  - RUN, STEP and NOP are accepted and dropped.
- **STEP:**
  - Each cycle with `pc_enable_out = 1` decrements the step counter.
  - When the counter is 1 and enabled, go to IDLE and pulse `done` next cycle.
  - `halt_hit` goes to DRAIN, with priority over the count.
  - ABORT goes to IDLE without a `done` pulse.
  - Other commands are dropped.
- **Priority in RUN/STEP:** ABORT over `halt_hit` over step completion.
- **DRAIN:**
  - The drain counter loads `DRAIN_CYCLES` on entry and decrements every cycle.
  - `pc_enable_out = 0` throughout.
  - When the count expires, go to DONE and pulse `done` on the entry cycle.
- **DONE:** sticky until `reset`; `halted = 1`, `pc_enable_out = 0`.
- **Pipeline stalls:** an internal pipeline stall still gates the PC inside the pipeline. STEP counts controller-enabled cycles, not retired instructions.

## Timing

- **Reset values:** state IDLE; `pc_enable_out = 0`, `cmd_ready = 1`, `busy = 0`, `done = 0`, `halted = 0`, `cycle_count = 0`; step and drain counters 0.
- **Reset mid-operation:** returns to IDLE immediately, asynchronously; no `done` pulse.
- **Command latency:** a command accepted at edge N changes the state at N; `pc_enable_out` responds in the cycle following N.
- **Halt latency:** if `halt_hit` is seen in cycle k, `pc_enable_out` is 0 in cycle k itself. DRAIN then lasts cycles k+1 through k+DRAIN_CYCLES, and `done`/`halted` rise in cycle k+DRAIN_CYCLES+1.
- **STEP N with no halt and no stalls:** exactly N cycles with `pc_enable_out = 1`, then IDLE; `done` is high in the first IDLE cycle.
- **`cycle_count`:** increments on every edge where `pc_enable_out = 1` and saturates at all-ones.

## Configuration

- **`PIPELINE_RUN_CONTROLLER_CYCLE_COUNT_EN`:**
  - Defined: the `cycle_count` register and incrementer are built as specified above.
  - Undefined: no counter logic is built and `cycle_count` is tied to 0.
  - All other behaviour is identical either way.

## Test plan

- **Reset then idle:** assert `reset` for 2 cycles, then 5 idle cycles. `pc_enable_out = 0`, `cmd_ready = 1`, `busy = 0`, `cycle_count = 0`.
- **STEP 3:** issue STEP with `cmd_arg = 3`, `pc_instr_in` never equal to HALT_INSTR. Exactly 3 consecutive enable cycles, then `done` pulses once and the state is IDLE with `cycle_count = 3`.
- **STEP 0:** issue STEP with `cmd_arg = 0`. Exactly 1 enable cycle followed by a `done` pulse.
- **RUN to halt:** issue RUN; present HALT_INSTR on the 10th enabled cycle. `pc_enable_out` drops in that same cycle, `busy` stays high for 4 more cycles, `done` pulses and `halted = 1`, `cycle_count = 9`, and `cmd_ready = 0` afterwards.
- **ABORT and halt together:** in RUN, present ABORT in the same cycle as `halt_hit`. The controller goes to IDLE, no DRAIN, no `done`; the next RUN command is accepted.
- **Reset during DRAIN:** assert `reset` on the 2nd DRAIN cycle. Immediate return to IDLE, `done` never pulses, `halted = 0`.
